// File: rtl/md_pkg.sv
// Shared definitions for the MDU issue queue: command encoding, queue entry
// layout and nominal MDU latencies.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MD_MULT_LAT = 5;
  localparam int MD_DIV_LAT  = 10;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
  } md_entry_t;

  function automatic logic md_is_legal(input logic [2:0] cmd);
    return (cmd <= MD_MTLO);
  endfunction

  function automatic logic md_is_move(input logic [2:0] cmd);
    return (cmd == MD_MTHI) || (cmd == MD_MTLO);
  endfunction

endpackage

// File: rtl/md_issue_queue_if.sv
// Issue bus between the command queue (master) and the multiply/divide unit
// (slave).
interface md_issue_queue_if;
  logic [31:0] md_in1;
  logic [31:0] md_in2;
  logic [2:0]  md_op;
  logic        md_chose;
  logic        md_change_hi;
  logic        md_change_lo;
  logic        md_start;
  logic        md_busy;

  modport master (
    output md_in1, md_in2, md_op, md_chose, md_change_hi, md_change_lo,
    input  md_start, md_busy
  );

  modport slave (
    input  md_in1, md_in2, md_op, md_chose, md_change_hi, md_change_lo,
    output md_start, md_busy
  );
endinterface

// File: rtl/md_fifo.sv
// Generic DEPTH-entry circular buffer of md_entry_t with a separate
// occupancy counter; push is ignored when full, pop when empty.
module md_fifo
  import md_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  md_entry_t        din,
  output md_entry_t        dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam int CNT_W = PTR_W + 1;

  md_entry_t          mem_r [DEPTH];
  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_s;
  logic               pop_s;

  // Qualify requests against the current fill state.
  always_comb begin
    full   = (count_r == CNT_W'(DEPTH));
    empty  = (count_r == {CNT_W{1'b0}});
    push_s = push && !full;
    pop_s  = pop && !empty;
    dout   = mem_r[head_r];
    count  = count_r;
  end

  // Storage, pointers and count; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_r[tail_r] <= din;
        tail_r        <= tail_r + 1'b1;
      end
      if (pop_s) begin
        head_r <= head_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/md_issue_queue.sv
// In-order command buffer in front of the MDU, with HI/LO read stall.
// Optional same-cycle bypass into an empty, idle queue: MDQ_BYPASS_EN.
module md_issue_queue
  import md_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              enq_valid,
  input  logic [2:0]        enq_cmd,
  input  logic [31:0]       enq_a,
  input  logic [31:0]       enq_b,
  output logic              enq_ready,
  output logic              enq_illegal,
  input  logic              rd_hilo,
  output logic              stall,
  output logic [PTR_W:0]    occupancy,
  md_issue_queue_if.master  mdu
);

  md_entry_t         head_s;
  md_entry_t         enq_entry_s;
  md_entry_t         sel_s;
  logic              sel_valid_s;
  logic              bypass_s;
  logic              full_s;
  logic              empty_s;
  logic [PTR_W:0]    count_s;
  logic              legal_s;
  logic              enq_fire_s;
  logic              issue_en_s;
  logic              move_s;
  logic              accepted_s;
  logic              push_s;
  logic              pop_s;
  logic              enq_illegal_r;

  md_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (enq_entry_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Enqueue qualification; reset gating keeps enq_ready low while in reset.
  always_comb begin
    enq_entry_s = '{cmd: enq_cmd, a: enq_a, b: enq_b};
    legal_s     = md_is_legal(enq_cmd);
    enq_ready   = reset && !full_s;
    enq_fire_s  = enq_valid && enq_ready && !req;
    occupancy   = count_s;
  end

  // Choose what drives the MDU: the head entry, or the incoming command when bypassing.
  always_comb begin
    sel_s       = head_s;
    sel_valid_s = !empty_s;
    bypass_s    = 1'b0;
`ifdef MDQ_BYPASS_EN
    if (empty_s && !mdu.md_busy && enq_fire_s && legal_s) begin
      sel_s       = enq_entry_s;
      sel_valid_s = 1'b1;
      bypass_s    = 1'b1;
    end else begin
      bypass_s    = 1'b0;
    end
`endif
  end

  // Issue decode; a move is accepted unconditionally, arithmetic only on md_start.
  always_comb begin
    issue_en_s       = sel_valid_s && !mdu.md_busy && !req && reset;
    move_s           = md_is_move(sel_s.cmd);
    mdu.md_chose     = issue_en_s && !move_s;
    mdu.md_change_hi = issue_en_s && (sel_s.cmd == MD_MTHI);
    mdu.md_change_lo = issue_en_s && (sel_s.cmd == MD_MTLO);
    if (sel_valid_s) begin
      mdu.md_in1 = sel_s.a;
      mdu.md_in2 = sel_s.b;
      mdu.md_op  = {1'b0, sel_s.cmd[1:0]};
    end else begin
      mdu.md_in1 = 32'h0000_0000;
      mdu.md_in2 = 32'h0000_0000;
      mdu.md_op  = 3'd0;
    end
    accepted_s = (mdu.md_chose && mdu.md_start) || (issue_en_s && move_s);
    pop_s      = accepted_s && !bypass_s;
    push_s     = enq_fire_s && legal_s && !(bypass_s && accepted_s);
    // The M-stage command is older than the mfhi/mflo in E, so it counts too.
    stall      = reset && rd_hilo &&
                 (enq_valid || !empty_s || mdu.md_busy || mdu.md_start);
  end

  // One-cycle pulse for a dropped illegal command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enq_illegal_r <= 1'b0;
    end else begin
      enq_illegal_r <= enq_fire_s && !legal_s;
    end
  end

  assign enq_illegal = enq_illegal_r;

endmodule

// File: tb/tb_md_issue_queue.sv
// Scoreboard bench for md_issue_queue with a behavioural MDU model.
module tb_md_issue_queue;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        enq_valid = 1'b0;
  logic [2:0]  enq_cmd = 3'd0;
  logic [31:0] enq_a = 32'h0;
  logic [31:0] enq_b = 32'h0;
  logic        enq_ready;
  logic        enq_illegal;
  logic        rd_hilo = 1'b0;
  logic        stall;
  logic [1:0]  occupancy;

  md_issue_queue_if mdu_if();

  md_issue_queue #(.DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .enq_valid   (enq_valid),
    .enq_cmd     (enq_cmd),
    .enq_a       (enq_a),
    .enq_b       (enq_b),
    .enq_ready   (enq_ready),
    .enq_illegal (enq_illegal),
    .rd_hilo     (rd_hilo),
    .stall       (stall),
    .occupancy   (occupancy),
    .mdu         (mdu_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  md_entry_t sb[$];

  // MDU model
  logic        mdu_en = 1'b0;
  int          busy_cnt = 0;
  logic [31:0] hi_m = 32'h0;
  logic [31:0] lo_m = 32'h0;

  assign mdu_if.md_busy  = (busy_cnt != 0);
  assign mdu_if.md_start = mdu_en && mdu_if.md_chose && !mdu_if.md_busy;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    return 64'($signed(a)) * 64'($signed(b));
  endfunction

  always @(posedge clk) begin
    if (mdu_if.md_start) begin
      busy_cnt <= (mdu_if.md_op < 3'd2) ? MD_MULT_LAT : MD_DIV_LAT;
      case (mdu_if.md_op)
        3'd0: {hi_m, lo_m} <= smul(mdu_if.md_in1, mdu_if.md_in2);
        3'd1: {hi_m, lo_m} <= {32'h0, mdu_if.md_in1} * {32'h0, mdu_if.md_in2};
        3'd2: if (mdu_if.md_in2 != 32'h0) begin
                lo_m <= $signed(mdu_if.md_in1) / $signed(mdu_if.md_in2);
                hi_m <= $signed(mdu_if.md_in1) % $signed(mdu_if.md_in2);
              end
        3'd3: if (mdu_if.md_in2 != 32'h0) begin
                lo_m <= mdu_if.md_in1 / mdu_if.md_in2;
                hi_m <= mdu_if.md_in1 % mdu_if.md_in2;
              end
        default: ;
      endcase
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (mdu_if.md_change_hi) hi_m <= mdu_if.md_in1;
    if (mdu_if.md_change_lo) lo_m <= mdu_if.md_in1;
  end

  // Scoreboard: push accepted legal commands, pop and compare on every issue.
  always @(negedge clk) begin
    md_entry_t e;
    logic [37:0] got, want;
    if (reset && enq_valid && enq_ready && !req && enq_cmd <= 3'd5)
      sb.push_back('{cmd: enq_cmd, a: enq_a, b: enq_b});
    if ((mdu_if.md_chose && mdu_if.md_start) || mdu_if.md_change_hi || mdu_if.md_change_lo) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got op %0d in1 %h with nothing pending", mdu_if.md_op, mdu_if.md_in1);
      end else begin
        e = sb.pop_front();
        got  = {mdu_if.md_op, mdu_if.md_chose, mdu_if.md_change_hi, mdu_if.md_change_lo};
        want = {1'b0, e.cmd[1:0], (e.cmd < 3'd4), (e.cmd == 3'd4), (e.cmd == 3'd5)};
        if (got[5:0] !== want[5:0] || mdu_if.md_in1 !== e.a || mdu_if.md_in2 !== e.b) begin
          errors++;
          $display("FAIL issue_order: got op/ctl %b a %h b %h want %b a %h b %h",
                   got[5:0], mdu_if.md_in1, mdu_if.md_in2, want[5:0], e.a, e.b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(occupancy == 2'd0 && busy_cnt == 0) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout: occupancy %0d busy %0d want 0 0", occupancy, busy_cnt);
    end
  endtask

  task automatic test_reset();
    rd_hilo = 1'b1; enq_valid = 1'b1; enq_cmd = MD_MULT;
    @(negedge clk);
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", enq_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
    tick(); reset = 1'b1; enq_valid = 1'b0; rd_hilo = 1'b0;
    @(negedge clk);
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rel: got %b want 1", enq_ready); end
    // fill the queue with the MDU refusing starts, then reset mid-queue
    mdu_en = 1'b0;
    tick(); enq_valid = 1'b1; enq_cmd = MD_MULT; enq_a = 32'd1; enq_b = 32'd2;
    tick(); enq_a = 32'd3; enq_b = 32'd4;
    tick(); enq_valid = 1'b0;
    @(negedge clk);
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL fill_occ: got %0d want 2", occupancy); end
    #2 reset = 1'b0; rd_hilo = 1'b1;
    #1;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL midrst_occ: got %0d want 0", occupancy); end
    checks++; if (mdu_if.md_chose !== 1'b0) begin errors++; $display("FAIL midrst_chose: got %b want 0", mdu_if.md_chose); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b want 0", stall); end
    sb.delete();
    tick(); reset = 1'b1; rd_hilo = 1'b0;
    @(negedge clk);
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", enq_ready); end
  endtask

  task automatic test_mult_mtlo();
    int n = 0;
    logic seen = 1'b0;
    mdu_en = 1'b1;
    tick(); enq_valid = 1'b1; enq_cmd = MD_MULT; enq_a = 32'hFFFF_FFFF; enq_b = 32'd2;
    tick(); enq_cmd = MD_MTLO; enq_a = 32'd7; enq_b = 32'd0;
    tick(); enq_valid = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk); n++;
      if (mdu_if.md_change_lo) begin
        seen = 1'b1;
        checks++;
        if (mdu_if.md_busy !== 1'b0) begin errors++; $display("FAIL mtlo_while_busy: got busy %b want 0", mdu_if.md_busy); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL mtlo_timeout: got no mtlo issue want one"); end
    tick();
    checks++; if (lo_m !== 32'd7) begin errors++; $display("FAIL lo_value: got %h want 00000007", lo_m); end
    checks++; if (hi_m !== 32'hFFFF_FFFF) begin errors++; $display("FAIL hi_value: got %h want ffffffff", hi_m); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    mdu_en = 1'b0;
    tick(); enq_valid = 1'b1; enq_cmd = MD_DIV; enq_a = 32'd100; enq_b = 32'd7;
    @(negedge clk);
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b want 1", enq_ready); end
    tick(); enq_a = 32'hFFFF_FFCE; enq_b = 32'd3;
    @(negedge clk);
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2: got %b want 1", enq_ready); end
    tick(); enq_a = 32'd9; enq_b = 32'd2; mdu_en = 1'b1;
    @(negedge clk);
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b want 0", enq_ready); end
    tick();
    @(negedge clk);
    checks++; if (enq_ready !== 1'b1 || occupancy !== 2'd1) begin
      errors++; $display("FAIL b2b_after_pop: got ready %b occ %0d want 1 1", enq_ready, occupancy); end
    tick(); enq_valid = 1'b0;
    @(negedge clk);
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL b2b_third_in: got %0d want 2", occupancy); end
    wait_idle();
  endtask

  task automatic test_stall();
    tick(); rd_hilo = 1'b1; enq_valid = 1'b1; enq_cmd = MD_MTHI; enq_a = 32'h55; enq_b = 32'h0;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_enq: got %b want 1", stall); end
    tick(); enq_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b want 0", stall); end
    tick(); enq_valid = 1'b1; enq_cmd = MD_MULTU; enq_a = 32'd6; enq_b = 32'd7;
    tick(); enq_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", stall); end
    rd_hilo = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_no_rd: got %b want 0", stall); end
    wait_idle();
  endtask

  task automatic test_req();
    mdu_en = 1'b0;
    tick(); enq_valid = 1'b1; enq_cmd = MD_DIVU; enq_a = 32'd40; enq_b = 32'd6;
    tick(); req = 1'b1; enq_cmd = MD_MULT; enq_a = 32'd1; enq_b = 32'd1; mdu_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (mdu_if.md_chose !== 1'b0 || occupancy !== 2'd1) begin
        errors++; $display("FAIL req_hold%0d: got chose %b occ %0d want 0 1", i, mdu_if.md_chose, occupancy); end
      if (i < 2) tick();
    end
    tick(); req = 1'b0; enq_valid = 1'b0;
    @(negedge clk);
    checks++; if (mdu_if.md_chose !== 1'b1 || mdu_if.md_op !== 3'd3) begin
      errors++; $display("FAIL req_resume: got chose %b op %0d want 1 3", mdu_if.md_chose, mdu_if.md_op); end
    tick();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL req_popped: got %0d want 0", occupancy); end
    wait_idle();
  endtask

  task automatic test_illegal();
    tick(); enq_valid = 1'b1; enq_cmd = 3'd7; enq_a = 32'hDEAD; enq_b = 32'hBEEF;
    @(negedge clk);
    checks++; if (enq_illegal !== 1'b0) begin errors++; $display("FAIL ill_early: got %b want 0", enq_illegal); end
    tick(); enq_valid = 1'b0;
    @(negedge clk);
    checks++; if (enq_illegal !== 1'b1 || occupancy !== 2'd0) begin
      errors++; $display("FAIL ill_pulse: got ill %b occ %0d want 1 0", enq_illegal, occupancy); end
    tick();
    @(negedge clk);
    checks++; if (enq_illegal !== 1'b0) begin errors++; $display("FAIL ill_width: got %b want 0", enq_illegal); end
  endtask

  task automatic test_latency();
    mdu_en = 1'b1;
    tick(); enq_valid = 1'b1; enq_cmd = MD_MULT; enq_a = 32'd3; enq_b = 32'd4;
    @(negedge clk);
`ifdef MDQ_BYPASS_EN
    checks++; if (mdu_if.md_chose !== 1'b1) begin errors++; $display("FAIL byp_chose: got %b want 1", mdu_if.md_chose); end
    tick(); enq_valid = 1'b0;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL byp_occ: got %0d want 0", occupancy); end
`else
    checks++; if (mdu_if.md_chose !== 1'b0) begin errors++; $display("FAIL lat_chose0: got %b want 0", mdu_if.md_chose); end
    tick(); enq_valid = 1'b0;
    @(negedge clk);
    checks++; if (mdu_if.md_chose !== 1'b1 || occupancy !== 2'd1) begin
      errors++; $display("FAIL lat_chose1: got chose %b occ %0d want 1 1", mdu_if.md_chose, occupancy); end
`endif
    tick();
    checks++; if (lo_m !== 32'd12) begin errors++; $display("FAIL lat_result: got %h want 0000000c", lo_m); end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_mult_mtlo();
    test_back_to_back();
    test_stall();
    test_req();
    test_illegal();
    test_latency();
    tick();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
